color_fsm_driver: RTL and testbench
===================================

COLOR_FSM_DRIVER -- requirements
Module: color_fsm_driver

Interface
REQ-001 Parameter CNT_W, default 8, width of the transaction and error counters.
REQ-002 Parameter IDLE_CMD, default 2'h3, command code driven when no command is in flight; a no-op in both colour states.
REQ-003 clk  input  1  clock; all state is on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  a colour-change request is present.
REQ-006 req_color  input  1  target colour: 0=Blue, 1=Red.
REQ-007 req_ready  output  1  driver accepts a request this cycle.
REQ-008 cmd  output  2  registered command to the colour FSM input (1=toggle, 0=hold Red).
REQ-009 rsp  input  2  Mealy output of the colour FSM, valid combinationally in the same cycle as cmd.
REQ-010 done_valid  output  1  completion record is present.
REQ-011 done_error  output  1  the response did not match the expected code.
REQ-012 done_color  output  1  shadow colour after completion.
REQ-013 done_ready  input  1  consumer takes the completion record.
REQ-014 cur_color  output  1  current shadow colour.
REQ-015 txn_count  output  CNT_W  number of completed transactions.
REQ-016 err_count  output  CNT_W  number of completions with an error.

Function
REQ-017 The driver SHALL implement the states IDLE, DRIVE and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE (combinational); a request is accepted when req_valid and req_ready are both 1 at a clock edge.
REQ-019 On accept with req_color != shadow, the driver SHALL go to DRIVE with cmd=2'h1 and expected response 2'h2 if the target is Red, or 2'h1 if the target is Blue.
REQ-020 On accept with req_color == shadow == Red, the driver SHALL go to DRIVE with cmd=2'h0 and expected response 2'h2.
REQ-021 On accept with req_color == shadow == Blue, the driver SHALL go directly to RESP with done_error=0, drive no command, and leave the shadow unchanged.
REQ-022 cmd SHALL be valid for exactly one cycle (the DRIVE cycle); it SHALL equal IDLE_CMD in every other cycle.
REQ-023 At the edge that ends DRIVE, the driver SHALL sample rsp, set done_error = (rsp != expected), and go to RESP.
REQ-024 At the same edge, the shadow SHALL update as follows: rsp=2'h2 sets Red; rsp=2'h1 sets Blue; any other value leaves the shadow unchanged.
REQ-025 In RESP, done_valid SHALL be 1, and done_error and done_color SHALL be held stable until done_valid and done_ready are both 1; the driver then returns to IDLE.
REQ-026 The minimum spacing between accepts SHALL be 3 cycles with a command and 2 cycles without.
REQ-027 txn_count SHALL increment by 1 on each done handshake and wrap from 2^CNT_W-1 to 0.
REQ-028 err_count SHALL increment on each done handshake with done_error=1 and saturate at 2^CNT_W-1.
REQ-029 req_valid in DRIVE or RESP SHALL be ignored; the request is not queued.
REQ-030 done_ready asserted outside RESP SHALL have no effect.
REQ-031 cur_color SHALL equal the shadow register at all times.

Reset
REQ-032 While rst=1, the driver SHALL hold: state IDLE, cmd=IDLE_CMD, shadow Red (cur_color=1), done_valid=0, done_error=0, done_color=1, txn_count=0, err_count=0.
REQ-033 Assertion of rst in any state, including DRIVE, SHALL apply REQ-032 immediately without waiting for a clock edge; the pending completion is discarded and the counters are not updated.
REQ-034 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-035 After reset, a request for Blue with rsp returning 2'h1 -> cmd=1 for one cycle, done_valid=1 with done_error=0 and done_color=0, txn_count=1.
REQ-036 From Blue, a request for Red with rsp=2'h2 -> cmd=1, done_color=1, done_error=0; a following request for Red -> cmd=0, rsp=2'h2, done_error=0, shadow stays Red.
REQ-037 From Red, a request for Blue with rsp forced to 2'h2 -> done_error=1, done_color=1, err_count=1.
REQ-038 From Blue, a request for Blue -> no cycle with cmd != 3, done_valid=1 on the cycle after accept, done_error=0.
REQ-039 done_ready held 0 for 5 cycles in RESP -> done_valid and done fields stable, req_ready=0, second req_valid ignored.
REQ-040 rst asserted during DRIVE -> cmd=3 and cur_color=1 immediately, done_valid=0, counters 0; 256 completions with CNT_W=8 -> txn_count wraps to 0, err_count saturates at 255 under forced errors.

Source files
------------

// File: rtl/color_fsm_driver.sv
// rtl/color_fsm_driver.sv - request/response driver for an external Red/Blue Mealy colour FSM
// Tracks a shadow of the colour FSM, issues one-cycle commands and reports checked completions.
module color_fsm_driver #(
  parameter int         CNT_W    = 8,
  parameter logic [1:0] IDLE_CMD = 2'h3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_color,
  output logic             req_ready,
  output logic [1:0]       cmd,
  input  logic [1:0]       rsp,
  output logic             done_valid,
  output logic             done_error,
  output logic             done_color,
  input  logic             done_ready,
  output logic             cur_color,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] CMD_TOGGLE   = 2'h1;
  localparam logic [1:0] CMD_HOLD_RED = 2'h0;
  localparam logic [1:0] RSP_RED      = 2'h2;
  localparam logic [1:0] RSP_BLUE     = 2'h1;
  localparam logic       RED          = 1'b1;
  localparam logic       BLUE         = 1'b0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             shadow;
  logic             shadow_upd;
  logic             accept;
  logic             need_cmd;
  logic [1:0]       cmd_q;
  logic [1:0]       exp_q;
  logic             err_q;
  logic             dcol_q;
  logic [CNT_W-1:0] txn_q;
  logic [CNT_W-1:0] errc_q;

  assign accept   = req_valid & req_ready;
  // Blue->Blue is the only request that needs no command: the FSM is already there.
  assign need_cmd = (req_color != shadow) || (req_color == RED);

  always_comb begin
    shadow_upd = shadow;
    if (rsp == RSP_RED)
      shadow_upd = RED;
    else if (rsp == RSP_BLUE)
      shadow_upd = BLUE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = need_cmd ? S_DRIVE : S_RESP;
      S_DRIVE: state_nxt = S_RESP;
      S_RESP:  if (done_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    done_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q  <= IDLE_CMD;
      exp_q  <= RSP_RED;
      shadow <= RED;
      err_q  <= 1'b0;
      dcol_q <= RED;
      txn_q  <= '0;
      errc_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (need_cmd) begin
              cmd_q <= (req_color != shadow) ? CMD_TOGGLE : CMD_HOLD_RED;
              exp_q <= (req_color == RED) ? RSP_RED : RSP_BLUE;
            end else begin
              err_q  <= 1'b0;
              dcol_q <= shadow;
            end
          end
        end
        S_DRIVE: begin
          // rsp is the Mealy answer to the command currently on cmd.
          cmd_q  <= IDLE_CMD;
          err_q  <= (rsp != exp_q);
          shadow <= shadow_upd;
          dcol_q <= shadow_upd;
        end
        S_RESP: begin
          if (done_ready) begin
            txn_q <= txn_q + CNT_W'(1);
            if (err_q && (errc_q != CNT_MAX))
              errc_q <= errc_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd        = cmd_q;
  assign done_error = err_q;
  assign done_color = dcol_q;
  assign cur_color  = shadow;
  assign txn_count  = txn_q;
  assign err_count  = errc_q;

endmodule

// File: tb/tb_color_fsm_driver.sv
// tb/tb_color_fsm_driver.sv - randomized self-checking bench for color_fsm_driver
// Transaction-level reference: shadow colour, external colour FSM and counters tracked as plain variables.
module tb_color_fsm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_color;
  logic       req_ready;
  logic [1:0] cmd;
  logic [1:0] rsp;
  logic       done_valid;
  logic       done_error;
  logic       done_color;
  logic       done_ready;
  logic       cur_color;
  logic [7:0] txn_count;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // reference state: 1 = Red, 0 = Blue
  logic m_shadow;
  logic m_ext;
  int   m_txn;
  int   m_err;

  color_fsm_driver dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_color  (req_color),
    .req_ready  (req_ready),
    .cmd        (cmd),
    .rsp        (rsp),
    .done_valid (done_valid),
    .done_error (done_error),
    .done_color (done_color),
    .done_ready (done_ready),
    .cur_color  (cur_color),
    .txn_count  (txn_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = 1'b1;
    m_ext    = 1'b1;
    m_txn    = 0;
    m_err    = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_cmd"}, cmd, 3);
    check({tag, "_cur_color"}, cur_color, m_shadow);
    check({tag, "_txn"}, txn_count, m_txn);
    check({tag, "_err"}, err_count, m_err);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic txn(input logic tgt, input bit force_en, input logic [1:0] fval, input int hold);
    bit         has_cmd;
    logic [1:0] exp_cmd;
    logic [1:0] exp_rsp;
    logic [1:0] r;
    logic       exp_err;
    logic       new_sh;
    has_cmd = (tgt != m_shadow) || tgt;
    exp_cmd = (tgt != m_shadow) ? 2'h1 : 2'h0;
    exp_rsp = tgt ? 2'h2 : 2'h1;

    check("acc_ready", req_ready, 1);
    check("acc_cmd", cmd, 3);
    req_valid  = 1'b1;
    req_color  = tgt;
    done_ready = 1'($urandom % 2);
    @(negedge clk);
    req_valid  = 1'b0;
    done_ready = 1'($urandom % 2);

    if (has_cmd) begin
      check("drv_cmd", cmd, exp_cmd);
      check("drv_done_valid", done_valid, 0);
      check("drv_req_ready", req_ready, 0);
      req_valid = 1'($urandom % 2);
      req_color = 1'($urandom % 2);
      // the external colour FSM answers with the code of the colour it moves to
      if (exp_cmd == 2'h1) m_ext = ~m_ext;
      else                 m_ext = 1'b1;
      r       = force_en ? fval : (m_ext ? 2'h2 : 2'h1);
      rsp     = r;
      exp_err = (r != exp_rsp);
      new_sh  = (r == 2'h2) ? 1'b1 : (r == 2'h1) ? 1'b0 : m_shadow;
      @(negedge clk);
      rsp = 2'h0;
    end else begin
      exp_err = 1'b0;
      new_sh  = m_shadow;
    end
    m_shadow = new_sh;

    for (int i = 0; i <= hold; i++) begin
      check("resp_done_valid", done_valid, 1);
      check("resp_done_error", done_error, exp_err);
      check("resp_done_color", done_color, new_sh);
      check("resp_cur_color", cur_color, new_sh);
      check("resp_req_ready", req_ready, 0);
      check("resp_cmd", cmd, 3);
      done_ready = (i == hold);
      req_valid  = (i == hold) ? 1'b0 : 1'($urandom % 2);
      req_color  = 1'($urandom % 2);
      @(negedge clk);
    end
    done_ready = 1'b0;
    m_txn = (m_txn + 1) % 256;
    if (exp_err && m_err < 255) m_err++;
    check_idle("post");
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_color  = 1'b0;
    rsp        = 2'h0;
    done_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cmd", cmd, 3);
    check("rst_cur_color", cur_color, 1);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_error", done_error, 0);
    check("rst_done_color", done_color, 1);
    check("rst_txn", txn_count, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;
    check_idle("first");

    // directed scenarios
    txn(1'b0, 1'b0, 2'h0, 0);   // Red -> Blue, correct response
    check("d1_txn", txn_count, 1);
    txn(1'b1, 1'b0, 2'h0, 0);   // Blue -> Red
    txn(1'b1, 1'b0, 2'h0, 1);   // Red -> Red, hold command
    txn(1'b0, 1'b1, 2'h2, 0);   // Red -> Blue, forced wrong response
    check("d4_err", err_count, 1);
    check("d4_color", cur_color, 1);
    txn(1'b0, 1'b1, 2'h1, 0);   // reach Blue
    txn(1'b0, 1'b0, 2'h0, 5);   // Blue -> Blue, no command, long stall

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      bit   fe;
      int   gap;
      fe = ($urandom % 4) == 0;
      txn(1'($urandom % 2), fe, 2'($urandom % 4), int'($urandom % 4));
      gap = int'($urandom % 3);
      for (int g = 0; g < gap; g++) begin
        done_ready = 1'($urandom % 2);
        @(negedge clk);
        done_ready = 1'b0;
        check_idle("gap");
      end
    end

    // asynchronous reset while a command is being driven
    req_valid = 1'b1;
    req_color = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_cmd_active", cmd != 2'h3, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rd_cmd", cmd, 3);
    check("rd_cur_color", cur_color, 1);
    check("rd_done_valid", done_valid, 0);
    check("rd_done_color", done_color, 1);
    check("rd_txn", txn_count, 0);
    check("rd_err", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rd_after");

    // counter wrap and saturation: Red -> Red with a bogus response every time
    for (int n = 0; n < 256; n++) txn(1'b1, 1'b1, 2'h0, 0);
    check("wrap_txn", txn_count, 0);
    check("sat_err", err_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
